// File: rtl/rom_read_arbiter.sv
// Two-client round-robin arbiter and read sequencer for a shared synchronous ROM.
// One read is outstanding at a time. The granted client gets a gnt pulse, then an rvalid pulse.
module rom_read_arbiter #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 8,
  parameter int ROM_LATENCY   = 1   // legal range 1..4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic                     req1,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     busy,
  output logic                     rom_ce,
  output logic                     rom_rd_en,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] WAIT_LOAD = 2'(ROM_LATENCY - 1);

  state_t                   state_r, state_s;
  logic                     ptr_r, ptr_s;        // 0: client 0 wins a tie
  logic                     client_r, client_s;
  logic [1:0]               cnt_r, cnt_s;
  logic                     gnt0_r, gnt0_s, gnt1_r, gnt1_s;
  logic                     rvalid0_r, rvalid0_s, rvalid1_r, rvalid1_s;
  logic [DATA_WIDTH-1:0]    rdata_r, rdata_s;
  logic                     busy_r, busy_s;
  logic                     rom_ce_r, rom_ce_s, rom_rd_en_r, rom_rd_en_s;
  logic [ADDRESS_WIDTH-1:0] rom_addr_r, rom_addr_s;
  logic                     pick_s;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    client_s    = client_r;
    cnt_s       = cnt_r;
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    rvalid0_s   = 1'b0;
    rvalid1_s   = 1'b0;
    rdata_s     = rdata_r;
    rom_ce_s    = 1'b0;
    rom_rd_en_s = 1'b1;
    rom_addr_s  = rom_addr_r;
    pick_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          if (req0 && req1) begin
            pick_s = ptr_r;
            ptr_s  = ~ptr_r;
          end else begin
            pick_s = req1;
            ptr_s  = ptr_r;
          end
          client_s    = pick_s;
          rom_addr_s  = pick_s ? addr1 : addr0;
          rom_ce_s    = 1'b1;
          rom_rd_en_s = 1'b0;
          gnt0_s      = ~pick_s;
          gnt1_s      = pick_s;
          state_s     = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        cnt_s   = WAIT_LOAD;
        state_s = WAIT;
      end
      WAIT: begin
        if (cnt_r != 2'd0) begin
          cnt_s = cnt_r - 2'd1;
        end else begin
          rdata_s   = rom_data;
          rvalid0_s = ~client_r;
          rvalid1_s = client_r;
          state_s   = DONE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset abandons any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= 1'b0;
      client_r    <= 1'b0;
      cnt_r       <= 2'd0;
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      rvalid0_r   <= 1'b0;
      rvalid1_r   <= 1'b0;
      rdata_r     <= {DATA_WIDTH{1'b0}};
      busy_r      <= 1'b0;
      rom_ce_r    <= 1'b0;
      rom_rd_en_r <= 1'b1;
      rom_addr_r  <= {ADDRESS_WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      client_r    <= client_s;
      cnt_r       <= cnt_s;
      gnt0_r      <= gnt0_s;
      gnt1_r      <= gnt1_s;
      rvalid0_r   <= rvalid0_s;
      rvalid1_r   <= rvalid1_s;
      rdata_r     <= rdata_s;
      busy_r      <= busy_s;
      rom_ce_r    <= rom_ce_s;
      rom_rd_en_r <= rom_rd_en_s;
      rom_addr_r  <= rom_addr_s;
    end
  end

  assign gnt0      = gnt0_r;
  assign gnt1      = gnt1_r;
  assign rvalid0   = rvalid0_r;
  assign rvalid1   = rvalid1_r;
  assign rdata     = rdata_r;
  assign busy      = busy_r;
  assign rom_ce    = rom_ce_r;
  assign rom_rd_en = rom_rd_en_r;
  assign rom_addr  = rom_addr_r;

endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Two-port round-robin arbiter and read sequencer in front of the shared synchronous ROM (registered output, read when ce=1 and rd_en=0).
- Accepts read requests from two independent clients, drives the ROM enables and address, waits the ROM read latency, and returns the word to the granted client with a one-cycle valid pulse.
- Sits between the ROM and its consumers, such as the display path and a test/sequencer client, so the ROM can be shared without contention.

Parameters:
- DATA_WIDTH, 16, ROM word width.
- ADDRESS_WIDTH, 8, ROM address width.
- ROM_LATENCY, 1, clock cycles from ROM enable to valid ROM output. Legal range is 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  client 0 read request; held with addr0 until gnt0.
- addr0  in  ADDRESS_WIDTH  client 0 read address.
- req1  in  1  client 1 read request; held with addr1 until gnt1.
- addr1  in  ADDRESS_WIDTH  client 1 read address.
- gnt0  out  1  one-cycle pulse: client 0 request accepted.
- gnt1  out  1  one-cycle pulse: client 1 request accepted.
- rvalid0  out  1  one-cycle pulse: rdata holds client 0's word.
- rvalid1  out  1  one-cycle pulse: rdata holds client 1's word.
- rdata  out  DATA_WIDTH  returned ROM word; shared by both clients and qualified by rvalid0/rvalid1.
- busy  out  1  high whenever the FSM is not in IDLE.
- rom_ce  out  1  ROM chip enable.
- rom_rd_en  out  1  ROM read enable, active low.
- rom_addr  out  ADDRESS_WIDTH  ROM address.
- rom_data  in  DATA_WIDTH  ROM registered data output.

Behaviour:
- All outputs are registered. All state changes on the rising edge of clk.
- Reset (rst=1 at a clock edge):
  - FSM goes to IDLE; priority pointer points to client 0.
  - gnt0, gnt1, rvalid0, rvalid1, busy, rom_ce = 0.
  - rom_rd_en = 1 (inactive); rom_addr = 0; rdata = 0; wait counter = 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If no request is present, stay in IDLE.
  - If exactly one req is high, select that client.
  - If both are high, select the client the pointer favours, then move the pointer to the other client.
  - On selection: latch the client id, load rom_addr from that client's address, set rom_ce=1, rom_rd_en=0, pulse that client's gnt, go to ISSUE.
  - After reset the pointer favours client 0.
- ISSUE: one cycle with the ROM enables asserted. At exit, rom_ce=0, rom_rd_en=1, gnt=0, wait counter = ROM_LATENCY-1, go to WAIT.
- WAIT:
  - While the counter is nonzero, decrement it and stay in WAIT.
  - When the counter is 0: rdata <= rom_data, raise rvalid for the latched client, go to DONE.
- DONE: rvalid is high for exactly this cycle. Clear it and return to IDLE. No new request is sampled in DONE.
- Latency: if req is sampled in IDLE at cycle T:
  - gnt is high during T+1.
  - rvalid is high during T+2+ROM_LATENCY.
  - The next grant can occur no earlier than T+4+ROM_LATENCY (sampled in IDLE at T+3+ROM_LATENCY).
  - Sustained throughput is one read per 3+ROM_LATENCY cycles.
- Simultaneous requests: strict alternation while both remain high.
- A req dropped before its gnt is a withdrawal: no gnt, no read.
- A req raised while busy is not lost; it is served when the FSM returns to IDLE, provided the client holds req.
- The address is captured only at grant. Changes to addrN after gnt do not affect the in-flight read.
- Only one read is outstanding at any time. rom_ce is high only in the ISSUE cycle.
- Address 2^ADDRESS_WIDTH-1 is legal. The address passes through unchanged with no wrap arithmetic.
- Reset mid-operation (any state): the read is abandoned, no rvalid is produced, all outputs take their reset values, and the pointer returns to client 0.

Test Plan:
- ROM[0x05]=0xABCD; req0=1 with addr0=0x05 sampled at T, ROM_LATENCY=1 -> gnt0=1 at T+1, rom_ce=1/rom_rd_en=0/rom_addr=0x05 at T+1, rvalid0=1 with rdata=0xABCD at T+3, rvalid1 never high.
- req0=req1=1 held continuously, addr0=0x10 (ROM=0x1111), addr1=0x20 (ROM=0x2222) -> grants in order 0,1,0,1 every 4 cycles; rdata alternates 0x1111 (rvalid0), 0x2222 (rvalid1).
- Only req1 held, addr1=0xFF (ROM=0xBEEF) -> gnt1 every 4 cycles; each rvalid1 carries 0xBEEF; busy low only in the IDLE cycle between reads.
- ROM_LATENCY=3, req0 at T addr0=0x00 (ROM=0x0042) -> gnt0 at T+1, rvalid0 at T+5 with rdata=0x0042.
- Read in flight, rst=1 in a WAIT cycle -> next cycle all outputs at reset values (rom_rd_en=1), no rvalid ever appears for that read; the next request with both req high is granted to client 0.
- req0 pulsed high for one cycle while busy, then low -> no gnt0, no rom_ce pulse for it after returning to IDLE.
